// File: rtl/hvsync_decoder_pkg.sv
// Shared types for the hsync/vsync timing decoder.
// Lock FSM encoding and counter geometry.
package hvsync_decoder_pkg;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LINE   = 2'd1,
        FRAME  = 2'd2,
        LOCKED = 2'd3
    } sync_state_e;

endpackage

// File: rtl/sync_edge_meter.sv
// One sync channel: polarity fold, trailing-edge pulse,
// saturating position counter and period capture/compare.
module sync_edge_meter
    import hvsync_decoder_pkg::*;
#(
    parameter logic POL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync,
    input  logic             inc,
    input  logic             restart,
    output logic             te,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] period,
    output logic             match
);

    logic             act;
    logic             act_q;
    logic             seen;
    logic [CNT_W-1:0] meas;

    assign act   = (sync == POL);
    assign te    = act_q && !act;
    assign meas  = cnt + CNT_W'(1);
    assign match = te && (meas == period);

    // The first edge after a restart only opens the measurement window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q  <= 1'b0;
            cnt    <= '0;
            period <= '0;
            seen   <= 1'b0;
        end else begin
            act_q <= act;
            if (te)
                cnt <= '0;
            else if (inc && cnt != CNT_MAX)
                cnt <= meas;
            if (te && seen && !restart)
                period <= meas;
            if (te)
                seen <= 1'b1;
            else if (restart)
                seen <= 1'b0;
        end
    end

endmodule

// File: rtl/hvsync_decoder.sv
// Recovers hpos/vpos/display_on from a sync stream and
// qualifies line and frame timing before declaring lock.
module hvsync_decoder
    import hvsync_decoder_pkg::*;
#(
    parameter int   H_DISPLAY = 256,
    parameter int   H_BACK    = 60,
    parameter int   V_DISPLAY = 240,
    parameter int   V_TOP     = 18,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       display_on,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked
);

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_BACK);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_BACK + H_DISPLAY);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_TOP);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_TOP + V_DISPLAY);

    sync_state_e      state;
    sync_state_e      state_nx;
    logic [1:0]       mcnt;
    logic [1:0]       mcnt_nx;
    logic             restart;
    logic             h_te;
    logic             v_te;
    logic             h_match;
    logic             v_match;
    logic             h_tmo;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    assign restart = (state == SEARCH);

    sync_edge_meter #(.POL(HSYNC_POL)) u_h (
        .clk     (clk),
        .reset   (reset),
        .sync    (hsync),
        .inc     (1'b1),
        .restart (restart),
        .te      (h_te),
        .cnt     (h_cnt),
        .period  (line_len),
        .match   (h_match)
    );

    sync_edge_meter #(.POL(VSYNC_POL)) u_v (
        .clk     (clk),
        .reset   (reset),
        .sync    (vsync),
        .inc     (h_te),
        .restart (restart),
        .te      (v_te),
        .cnt     (v_cnt),
        .period  (frame_lines),
        .match   (v_match)
    );

    // Timeout fires as h_cnt steps onto its saturation value.
    assign h_tmo = (h_cnt == CNT_TMO) && !h_te;

    always_comb begin
        state_nx = state;
        mcnt_nx  = mcnt;
        unique case (state)
            SEARCH: begin
                if (h_te)
                    state_nx = LINE;
            end
            LINE: begin
                if (h_te)
                    mcnt_nx = !h_match     ? 2'd0 :
                              mcnt == 2'd3 ? mcnt : mcnt + 2'd1;
                if (v_te && mcnt >= 2'd2)
                    state_nx = FRAME;
            end
            FRAME: begin
                if (v_te && v_match)
                    state_nx = LOCKED;
            end
            LOCKED: begin
                if ((h_te && !h_match) || (v_te && !v_match))
                    state_nx = LINE;
            end
        endcase
        if (h_tmo)
            state_nx = SEARCH;
        if (state_nx != LINE)
            mcnt_nx = 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= SEARCH;
            mcnt   <= 2'd0;
            locked <= 1'b0;
        end else begin
            state  <= state_nx;
            mcnt   <= mcnt_nx;
            locked <= (state_nx == LOCKED);
        end
    end

    assign display_on = locked &&
                        h_cnt >= H_LO && h_cnt < H_HI &&
                        v_cnt >= V_LO && v_cnt < V_HI;

    assign hpos = display_on ? 9'(h_cnt - H_LO) : 9'd0;
    assign vpos = display_on ? 9'(v_cnt - V_LO) : 9'd0;

endmodule

// File: tb/tb_hvsync_decoder.sv
// Directed bench: a 381-clock line generator with a short frame
// drives an active-high and an active-low decoder in parallel.
module tb_hvsync_decoder;

    localparam int HT = 381;
    localparam int VT = 9;

    logic       clk;
    logic       reset;
    logic       hsync, vsync, hsync_b, vsync_b;
    logic [8:0] hpos_a, vpos_a, hpos_b, vpos_b;
    logic       disp_a, disp_b, locked_a, locked_b;
    logic [9:0] ll_a, fl_a, ll_b, fl_b;

    int gx, gy;
    bit h_kill;
    int vectors, misc;

    hvsync_decoder #(
        .H_DISPLAY(256), .H_BACK(60), .V_DISPLAY(4), .V_TOP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .hpos(hpos_a), .vpos(vpos_a), .display_on(disp_a),
        .line_len(ll_a), .frame_lines(fl_a), .locked(locked_a)
    );

    hvsync_decoder #(
        .H_DISPLAY(256), .H_BACK(60), .V_DISPLAY(4), .V_TOP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .hsync(hsync_b), .vsync(vsync_b),
        .hpos(hpos_b), .vpos(vpos_b), .display_on(disp_b),
        .line_len(ll_b), .frame_lines(fl_b), .locked(locked_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gy;
        int gx;
        int hp;
        int vp;
        int d;
    } vec_t;

    // Sync ends on the last clock of a line so that h_cnt == gx
    // and v_cnt == gy once locked; the vsync edge coincides with hsync.
    task automatic drive();
        int gyp;
        gyp = (gx == HT - 1) ? (gy + 1) % VT : gy;
        hsync = !h_kill && gx >= 355 && gx <= 379;
        vsync = (gyp == VT - 1);
        hsync_b = ~hsync;
        vsync_b = ~vsync;
    endtask

    task automatic tick(input bit stall = 1'b0);
        @(posedge clk);
        #1;
        if (!stall) begin
            if (gx == HT - 1) begin
                gx = 0;
                gy = (gy + 1) % VT;
            end else begin
                gx++;
            end
        end
        drive();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s: got %0d expected %0d (gy=%0d gx=%0d)",
                     name, act, exp, gy, gx);
        end
    endtask

    task automatic goto(input int y, input int x);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(gx == x && gy == y) && n <= HT * VT);
        if (!(gx == x && gy == y)) begin
            vectors++;
            misc++;
            $display("FAIL goto: position %0d,%0d not reached", y, x);
        end
    endtask

    task automatic wait_lock(input int budget);
        int n;
        n = 0;
        while (!locked_a && n < budget) begin
            tick();
            n++;
        end
        chk("relock", locked_a, 1);
    endtask

    vec_t tbl[9];

    initial begin
        vectors = 0;
        misc = 0;
        tbl[0] = '{2,   60,   0, 0, 0};
        tbl[1] = '{3,   59,   0, 0, 0};
        tbl[2] = '{3,   60,   0, 0, 1};
        tbl[3] = '{3,   61,   1, 0, 1};
        tbl[4] = '{4,  160, 100, 1, 1};
        tbl[5] = '{5,  300, 240, 2, 1};
        tbl[6] = '{6,  315, 255, 3, 1};
        tbl[7] = '{6,  316,   0, 0, 0};
        tbl[8] = '{7,  100,   0, 0, 0};

        reset = 1'b0;
        h_kill = 1'b0;
        gx = 0;
        gy = 0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked_a, 0);
        chk("rst_disp", disp_a, 0);
        chk("rst_hpos", hpos_a, 0);
        chk("rst_line_len", ll_a, 0);
        chk("rst_frame_lines", fl_a, 0);
        reset = 1'b1;

        // acquisition from reset
        goto(1, 0);
        chk("line_len_1st", ll_a, 0);
        goto(2, 0);
        chk("line_len_2nd", ll_a, 381);
        goto(0, 0);
        chk("frame_lines_1st", fl_a, 0);
        goto(0, 0);
        chk("frame_lines_2nd", fl_a, 9);
        chk("locked_f2", locked_a, 0);
        goto(8, 380);
        chk("locked_pre", locked_a, 0);
        chk("locked_pre_b", locked_b, 0);
        tick();
        chk("locked_post", locked_a, 1);
        chk("locked_post_b", locked_b, 1);

        foreach (tbl[i]) begin
            goto(tbl[i].gy, tbl[i].gx);
            chk("hpos_a", hpos_a, tbl[i].hp);
            chk("vpos_a", vpos_a, tbl[i].vp);
            chk("disp_a", disp_a, tbl[i].d);
            chk("hpos_b", hpos_b, tbl[i].hp);
            chk("vpos_b", vpos_b, tbl[i].vp);
            chk("disp_b", disp_b, tbl[i].d);
        end

        // one stretched line
        goto(2, 200);
        chk("str_locked_in", locked_a, 1);
        tick(1'b1);
        goto(2, 380);
        chk("str_locked_te", locked_a, 1);
        tick();
        chk("str_locked_drop", locked_a, 0);
        chk("str_line_len", ll_a, 382);
        goto(4, 0);
        chk("str_line_len_back", ll_a, 381);
        goto(0, 0);
        chk("str_locked_frame", locked_a, 0);
        goto(8, 380);
        chk("str_locked_pre", locked_a, 0);
        tick();
        chk("str_relock", locked_a, 1);
        chk("str_frame_lines", fl_a, 9);

        // hsync stops
        goto(1, 0);
        chk("tmo_locked_in", locked_a, 1);
        h_kill = 1'b1;
        drive();
        repeat (1022) tick();
        chk("tmo_locked_1022", locked_a, 1);
        tick();
        chk("tmo_locked_1023", locked_a, 0);
        chk("tmo_locked_1023_b", locked_b, 0);
        repeat (100) tick();
        chk("tmo_disp", disp_a, 0);
        chk("tmo_hpos", hpos_a, 0);
        chk("tmo_vpos", vpos_a, 0);
        chk("tmo_line_len", ll_a, 381);
        chk("tmo_frame_lines", fl_a, 9);
        h_kill = 1'b0;
        drive();
        wait_lock(5 * HT * VT);

        // reset in the middle of a visible line
        goto(4, 160);
        chk("mid_hpos", hpos_a, 100);
        chk("mid_vpos", vpos_a, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_hpos", hpos_a, 0);
        chk("arst_vpos", vpos_a, 0);
        chk("arst_disp", disp_a, 0);
        chk("arst_locked", locked_a, 0);
        chk("arst_line_len", ll_a, 0);
        chk("arst_frame_lines", fl_a, 0);
        tick();
        tick();
        reset = 1'b1;
        begin
            int hi;
            hi = 0;
            for (int n = 0; n < 2 * HT * VT; n++) begin
                tick();
                if (locked_a || locked_b)
                    hi++;
            end
            chk("arst_hold_2frames", hi, 0);
        end
        wait_lock(2 * HT * VT);
        goto(4, 160);
        chk("relock_hpos", hpos_a, 100);
        chk("relock_hpos_b", hpos_b, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/hvsync_decoder.md
Name: hvsync_decoder

Overview:
- Receive-side counterpart of the sync generator: consumes hsync/vsync produced by a video timing source and recovers hpos, vpos and display_on.
- Measures line period and frame height, and asserts locked once the timing is stable.
- Sits in front of capture/overlay logic and loopback test benches; the timing source is synchronous to clk.

Parameters:
- H_DISPLAY, 256, visible pixels per line
- H_BACK, 60, clocks from hsync trailing edge to first visible pixel
- V_DISPLAY, 240, visible lines per frame
- V_TOP, 18, lines from vsync trailing edge to first visible line
- HSYNC_POL, 1, asserted level of hsync input
- VSYNC_POL, 1, asserted level of vsync input

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, polarity HSYNC_POL, synchronous to clk
- vsync  in  1  vertical sync, polarity VSYNC_POL, synchronous to clk
- hpos  out  9  recovered column; 0 when display_on=0
- vpos  out  9  recovered row; 0 when display_on=0
- display_on  out  1  locked and current clock inside visible window
- line_len  out  10  last measured clocks between hsync trailing edges
- frame_lines  out  10  last measured lines between vsync trailing edges
- locked  out  1  timing stable

Behaviour:
- Reset (reset=0, async): all counters 0, all outputs 0, FSM=SEARCH, sync history registers hold deasserted.
- Normalisation: hs = (hsync==HSYNC_POL), vs = (vsync==VSYNC_POL).
- Edge detection: hs_q, vs_q registered each clk. Trailing edge (h_te/v_te) = q==1 && current==0, evaluated combinationally in the cycle the input first reads deasserted.
- h_cnt (10b):
  - h_te → h_cnt<=0.
  - Otherwise h_cnt<=h_cnt+1, saturating at 1023.
  - h_cnt=0 in the cycle after the first deasserted sample.
- v_cnt (10b):
  - v_te → v_cnt<=0. v_te wins over a simultaneous h_te.
  - h_te without v_te → v_cnt+1, saturating at 1023.
- line_len: on h_te, line_len<=h_cnt+1, except on the first h_te after SEARCH.
- frame_lines: on v_te, frame_lines<=v_cnt+1, except on the first v_te after SEARCH.
- FSM states SEARCH, LINE, FRAME, LOCKED:
  - SEARCH: first h_te → LINE.
  - LINE: a 2-bit match counter counts consecutive h_te where new period == line_len (mismatch clears it). Counter ≥2 and v_te → FRAME.
  - FRAME: on the next v_te, new frame_lines == stored → LOCKED. Otherwise stay in FRAME with the new value stored.
  - LOCKED: any h_te period ≠ line_len, or v_te count ≠ frame_lines → LINE (counter cleared). The new measurement is stored.
  - Any state: h_cnt reaching 1023 (no hsync) → SEARCH, locked=0, line_len/frame_lines keep last values.
- locked = (state==LOCKED), registered; changes the cycle after the deciding edge.
- display_on = locked && H_BACK ≤ h_cnt < H_BACK+H_DISPLAY && V_TOP ≤ v_cnt < V_TOP+V_DISPLAY.
- hpos/vpos:
  - Combinational from registered counters, zero output latency relative to h_cnt/v_cnt.
  - hpos = h_cnt−H_BACK and vpos = v_cnt−V_TOP, truncated to 9b.
  - Both 0 when !display_on.
- Reset mid-frame: immediate return to SEARCH. Relock requires full LINE+FRAME qualification (≥2 vsync periods).
- Period > 1023 is unsupported: treated as timeout.

Decomposition:
- Shared package: FSM state encodings (SEARCH=0, LINE=1, FRAME=2, LOCKED=3) and a counter width constant (10).
- One natural sub-module: sync_edge_meter, instantiated twice (h and v). It contains polarity normalisation, history register, trailing-edge pulse, saturating counter with increment enable, period capture and match flag.
- FSM and window compare stay in the top level.

Test Plan:
- Drive from sync generator timing (256/60/40/25, 240/18/14/4), active-high: line_len=381 after 2nd hsync; frame_lines=276 after 2nd vsync; locked rises the cycle after the 3rd v_te; first display_on with hpos=0,vpos=0 at h_cnt=60,v_cnt=18; last visible hpos=255,vpos=239.
- Locked stream, one line stretched to 382 clocks → locked drops 1 cycle after that h_te, line_len=382, then 381. Relock after two matching lines plus two matching frames.
- Stop hsync (held deasserted) while locked → locked=0 and FSM=SEARCH exactly when h_cnt hits 1023. display_on=0 and hpos=vpos=0 thereafter.
- Active-low source with HSYNC_POL=VSYNC_POL=0, identical timing → same lock point and same hpos/vpos sequence as the first test.
- Assert reset (low) mid-visible-line at hpos=100 → all outputs 0 asynchronously. After release, locked stays 0 for ≥2 full frames.
- Simultaneous hsync and vsync trailing edges → v_cnt=0 (not 1); the next line gives v_cnt=1.
